// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the banked data memory:
//   - dmem_state_e : initialisation / run FSM encoding
//   - DMEM_*       : default width constants used by the interface and modules
//   - prio_lowest  : fixed-priority (lowest index wins) one-hot grant helper
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    localparam int DMEM_N_CORES = 4;
    localparam int DMEM_DATA_W  = 12;
    localparam int DMEM_BUS_W   = 18;
    localparam int DMEM_ADDR_W  = 12;

    // Widest request vector the grant helper handles; N_CORES must not exceed it.
    localparam int MAX_CORES    = 32;

    // Isolates the lowest set bit: v & (-v) in two's complement.
    function automatic logic [MAX_CORES-1:0] prio_lowest(input logic [MAX_CORES-1:0] req_v);
        return req_v & (~req_v + 32'd1);
    endfunction

endpackage

// File: rtl/banked_dmem_if.sv
// -----------------------------------------------------------------------------
// banked_dmem_if
// Bus bundle between the processing cores / host and banked_dmem.
// Per-core fields are flattened, core i in slice i.
//   req/we/bcast [N]     : core request, write, broadcast qualifiers
//   addr  [N*ADDR_W]     : per-core address
//   wdata [N*BUS_W]      : per-core write data (low DATA_W bits stored)
//   ready/rvalid [N]     : accept (combinational) / read data valid (registered)
//   rdata [N*DATA_W]     : per-core read data
//   hst_req/hst_addr     : host readback request and address
//   hst_rvalid/hst_rdata : host data valid and OR of all banks
// Modports: master (cores/host side), slave (memory side).
// -----------------------------------------------------------------------------
interface banked_dmem_if
    import dmem_pkg::*;
#(
    parameter int N_CORES = DMEM_N_CORES,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int BUS_W   = DMEM_BUS_W,
    parameter int ADDR_W  = DMEM_ADDR_W
);
    logic [N_CORES-1:0]        req;
    logic [N_CORES-1:0]        we;
    logic [N_CORES-1:0]        bcast;
    logic [N_CORES*ADDR_W-1:0] addr;
    logic [N_CORES*BUS_W-1:0]  wdata;
    logic [N_CORES-1:0]        ready;
    logic [N_CORES-1:0]        rvalid;
    logic [N_CORES*DATA_W-1:0] rdata;
    logic                      hst_req;
    logic [ADDR_W-1:0]         hst_addr;
    logic                      hst_rvalid;
    logic [DATA_W-1:0]         hst_rdata;

    modport master (
        output req, we, bcast, addr, wdata, hst_req, hst_addr,
        input  ready, rvalid, rdata, hst_rvalid, hst_rdata
    );

    modport slave (
        input  req, we, bcast, addr, wdata, hst_req, hst_addr,
        output ready, rvalid, rdata, hst_rvalid, hst_rdata
    );
endinterface

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// One DEPTH x DATA_W RAM bank with a synchronous write port and two registered
// read ports (core and host). Reads sample the array before the same-edge write
// lands, so a same-address read/write returns the old word.
// Ports:
//   clk, rst_n          : clock, async active-low reset (read registers only)
//   we_i/waddr_i/wdata_i: write port
//   rd_en_i/raddr_i     : core read request, rdata_o holds until next read
//   hrd_en_i/haddr_i    : host read request, hrdata_o holds until next read
// Array contents are not reset; an external preload may fill them.
// -----------------------------------------------------------------------------
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              hrd_en_i,
    input  logic [ADDR_W-1:0] haddr_i,
    output logic [DATA_W-1:0] hrdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] hrdata_q;

    // Storage array write port (no reset on contents).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read ports; each holds its last word until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= {DATA_W{1'b0}};
            hrdata_q <= {DATA_W{1'b0}};
        end else begin
            if (rd_en_i) begin
                rdata_q <= mem_q[raddr_i];
            end
            if (hrd_en_i) begin
                hrdata_q <= mem_q[haddr_i];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign hrdata_o = hrdata_q;

endmodule

// File: rtl/banked_dmem.sv
// -----------------------------------------------------------------------------
// banked_dmem
// Multi-core data memory: one private bank per core plus broadcast writes,
// fixed-priority broadcast arbitration, an OR-combining host readback port and
// a power-up INIT/RUN FSM that gates start_process.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   bus           : banked_dmem_if.slave (core and host request/response)
//   start_process : high exactly while the FSM is in RUN
// Build option: DMEM_INIT_CLEAR_EN -- when defined, INIT writes zero to every
// address of every bank (one address per cycle) before entering RUN; otherwise
// INIT lasts one cycle and contents come from any preload.
// -----------------------------------------------------------------------------
module banked_dmem
    import dmem_pkg::*;
#(
    parameter int N_CORES = DMEM_N_CORES,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int BUS_W   = DMEM_BUS_W,
    parameter int ADDR_W  = DMEM_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    banked_dmem_if.slave bus,
    output logic         start_process
);
    localparam int DEPTH = 2 ** ADDR_W;
    // One extra bit so the counter can reach DEPTH, marking "sweep done".
    localparam int CNT_W = ADDR_W + 1;

    dmem_state_e          state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;

    logic                 run_s;
    logic                 clr_we_s;
    logic [ADDR_W-1:0]    clr_addr_s;
    logic [N_CORES-1:0]   bc_req_s;
    logic [N_CORES-1:0]   bc_gnt_s;
    logic                 bc_any_s;
    logic [ADDR_W-1:0]    bc_addr_s;
    logic [DATA_W-1:0]    bc_data_s;
    logic [N_CORES-1:0]   ready_s;
    logic [N_CORES-1:0]   rd_en_s;
    logic                 hst_en_s;
    logic [N_CORES-1:0]   bank_we_s;
    logic [ADDR_W-1:0]    bank_waddr_s [N_CORES];
    logic [DATA_W-1:0]    bank_wdata_s [N_CORES];
    logic [DATA_W-1:0]    bank_rdata_s [N_CORES];
    logic [DATA_W-1:0]    bank_hrdata_s[N_CORES];
    logic [N_CORES*DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0]    hst_or_s;
    logic [N_CORES-1:0]   rvalid_q;
    logic                 hst_rvalid_q;
    logic                 wdata_unused_s;

    // FSM state and clear-sweep counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // FSM next state: INIT finishes once the sweep (if built in) is complete.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
                // Counter reaches DEPTH the edge after address DEPTH-1 is cleared.
                if (clr_cnt_q == CNT_W'(DEPTH)) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
`else
                state_d = RUN;
`endif
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // FSM outputs: accept logic, broadcast arbitration and bank write muxing.
    always_comb begin
        run_s         = (state_q == RUN);
        start_process = run_s;
        clr_addr_s    = clr_cnt_q[ADDR_W-1:0];
`ifdef DMEM_INIT_CLEAR_EN
        if ((state_q == INIT) && !clr_cnt_q[ADDR_W]) begin
            clr_we_s = 1'b1;
        end else begin
            clr_we_s = 1'b0;
        end
`else
        clr_we_s = 1'b0;
`endif
        if (run_s) begin
            bc_req_s = bus.req & bus.we & bus.bcast;
        end else begin
            bc_req_s = {N_CORES{1'b0}};
        end
        bc_gnt_s = N_CORES'(prio_lowest(MAX_CORES'(bc_req_s)));
        bc_any_s = |bc_req_s;
        hst_en_s = run_s & bus.hst_req;

        // Grant is one-hot, so OR-ing masked slices selects the winner.
        bc_addr_s = {ADDR_W{1'b0}};
        bc_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_CORES; i++) begin
            bc_addr_s = bc_addr_s | ({ADDR_W{bc_gnt_s[i]}} & bus.addr[i*ADDR_W +: ADDR_W]);
            bc_data_s = bc_data_s | ({DATA_W{bc_gnt_s[i]}} & bus.wdata[i*BUS_W +: DATA_W]);
        end

        for (int i = 0; i < N_CORES; i++) begin
            ready_s[i]      = 1'b0;
            bank_we_s[i]    = 1'b0;
            bank_waddr_s[i] = bus.addr[i*ADDR_W +: ADDR_W];
            bank_wdata_s[i] = bus.wdata[i*BUS_W +: DATA_W];
            rd_en_s[i]      = run_s & bus.req[i] & ~bus.we[i];

            if (!run_s || !bus.req[i]) begin
                ready_s[i] = 1'b0;
            end else if (!bus.we[i]) begin
                ready_s[i] = 1'b1;
            end else if (bus.bcast[i]) begin
                ready_s[i] = bc_gnt_s[i];
            end else begin
                // Local writes yield to any granted broadcast.
                ready_s[i] = ~bc_any_s;
            end

            if (clr_we_s) begin
                bank_we_s[i]    = 1'b1;
                bank_waddr_s[i] = clr_addr_s;
                bank_wdata_s[i] = {DATA_W{1'b0}};
            end else if (bc_any_s) begin
                bank_we_s[i]    = 1'b1;
                bank_waddr_s[i] = bc_addr_s;
                bank_wdata_s[i] = bc_data_s;
            end else begin
                bank_we_s[i]    = ready_s[i] & bus.we[i];
                bank_waddr_s[i] = bus.addr[i*ADDR_W +: ADDR_W];
                bank_wdata_s[i] = bus.wdata[i*BUS_W +: DATA_W];
            end
        end
    end

    // Read-valid pulses, one cycle after each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q     <= {N_CORES{1'b0}};
            hst_rvalid_q <= 1'b0;
        end else begin
            rvalid_q     <= rd_en_s;
            hst_rvalid_q <= hst_en_s;
        end
    end

    for (genvar g = 0; g < N_CORES; g++) begin : g_bank
        dmem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (bank_we_s[g]),
            .waddr_i  (bank_waddr_s[g]),
            .wdata_i  (bank_wdata_s[g]),
            .rd_en_i  (rd_en_s[g]),
            .raddr_i  (bus.addr[g*ADDR_W +: ADDR_W]),
            .rdata_o  (bank_rdata_s[g]),
            .hrd_en_i (hst_en_s),
            .haddr_i  (bus.hst_addr),
            .hrdata_o (bank_hrdata_s[g])
        );
    end

    // Pack per-bank read data and OR the host words across banks.
    always_comb begin
        rdata_s  = {(N_CORES*DATA_W){1'b0}};
        hst_or_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_CORES; i++) begin
            rdata_s[i*DATA_W +: DATA_W] = bank_rdata_s[i];
            hst_or_s                    = hst_or_s | bank_hrdata_s[i];
        end
    end

    // Upper write-data bits beyond DATA_W are intentionally discarded.
    assign wdata_unused_s = ^bus.wdata;

    assign bus.ready      = ready_s;
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_s;
    assign bus.hst_rvalid = hst_rvalid_q;
    assign bus.hst_rdata  = hst_or_s;

endmodule

// File: doc/banked_dmem.md
# banked_dmem

Parametrised multi-core data memory for the matrix-multiply array: one private RAM bank per core, each with a local read/write port. Adds broadcast writes with fixed-priority arbitration, a host readback port that ORs all banks, and a power-up initialisation FSM that gates `start_process`. Sits between the processing cores and the shared bus/testbench, replacing the fixed four-bank, 12-bit memory.

## Interface
- `N_CORES`, default 4: number of cores, which is also the number of banks.
- `DATA_W`, default 12: stored word width.
- `BUS_W`, default 18: write-data width from the bus. Must satisfy BUS_W >= DATA_W.
- `ADDR_W`, default 12: address width. DEPTH = 2**ADDR_W words per bank.

Ports (per-core signals are flattened, core i in slice i):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_CORES: core i access request.
- `we` in N_CORES: write when 1, read when 0.
- `bcast` in N_CORES: with `we`, write the word to the same address in all banks.
- `addr` in N_CORES*ADDR_W: per-core address.
- `wdata` in N_CORES*BUS_W: per-core write data; low DATA_W bits are stored.
- `ready` out N_CORES: request accepted this cycle.
- `rvalid` out N_CORES: read data valid.
- `rdata` out N_CORES*DATA_W: per-core read data.
- `hst_req` in 1: host readback request.
- `hst_addr` in ADDR_W: host address.
- `hst_rvalid` out 1: host data valid.
- `hst_rdata` out DATA_W: OR of all banks at `hst_addr`.
- `start_process` out 1: memory ready; cores may start.

## Operation
- FSM states:
  - INIT: clear sweep, or a single cycle when the clear feature is compiled out.
  - RUN: normal accesses.
  - INIT -> RUN when initialisation completes. RUN is held until reset.
- In INIT, `ready`, `rvalid` and `hst_rvalid` are 0 and all requests are ignored. `start_process` = 1 exactly in RUN.
- Local read (`req`=1, `we`=0): always accepted in RUN. Reads bank i at `addr[i]`.
- Local write (`req`=1, `we`=1, `bcast`=0): writes bank i. Accepted unless a broadcast is granted in the same cycle.
- Broadcast write (`req`=1, `we`=1, `bcast`=1): at most one grant per cycle, to the lowest-index requesting core.
  - The grant writes the same address and data into all banks.
  - Losing broadcasters and all local writers get `ready`=0 and must hold their request.
  - Reads in that cycle are unaffected.
- Read and write to the same bank and address in the same cycle: read-before-write, so the old data is returned.
- Host read: always accepted in RUN. `hst_rdata` = bitwise OR of bank[k][hst_addr] over all k.
- Width rules: `wdata[i][DATA_W-1:0]` is stored and upper bits are discarded. Addresses use the full ADDR_W range, no wrap logic.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `rdata`=0, `hst_rvalid`=0, `hst_rdata`=0, `start_process`=0, FSM=INIT, clear counter=0. Memory contents are not reset.
- `ready` is combinational from `req`/`we`/`bcast` and FSM state.
- Write takes effect at the accepting edge and is visible to reads issued the next cycle.
- Read latency is 1 cycle: `rvalid[i]`/`rdata[i]` are registered and valid the cycle after acceptance. `rvalid` is a one-cycle pulse; `rdata` holds its value until the next read.
- Host read latency is 1 cycle, with the same pulse and hold rules.
- Reset asserted mid-operation: immediate return to INIT, in-flight reads are dropped, all outputs go to reset values.

## Configuration
- `DMEM_INIT_CLEAR_EN` defined:
  - INIT sweeps addresses 0..DEPTH-1, one per cycle, writing 0 to all banks.
  - RUN is entered the cycle after address DEPTH-1 is written, so `start_process` rises DEPTH+1 cycles after reset release.
- Undefined:
  - INIT lasts one cycle and `start_process` rises 1 cycle after reset release.
  - Contents are whatever preload (`$readmemb`) supplied.

## Structure
- Package `dmem_pkg`:
  - FSM state enum (INIT, RUN).
  - Default width constants (DATA_W, BUS_W, ADDR_W).
  - A priority-encode function for broadcast grant.
- Sub-module `dmem_bank`: one DEPTH x DATA_W bank.
  - One synchronous write port and two read ports: core read and host read, both registered, read-before-write.
  - `banked_dmem` instantiates N_CORES of them and holds the FSM, arbitration and OR-reduction.

## Test plan
Defaults are used, and the clear feature is compiled in unless stated.
- Reset release with clear enabled -> `start_process` rises at cycle 4097; every request before that sees `ready`=0; a host read of address 5 afterwards returns 0.
- Core 2 writes 0x3ABC to address 0x100, then reads it -> stored value 0xABC; `rvalid[2]` pulses 1 cycle after the read is accepted; other banks at 0x100 stay 0.
- Cores 1 and 3 broadcast simultaneously (addr 0x010, data 0x111 and 0x333) -> core 1 is granted and core 3 sees `ready`=0; the next cycle core 3 is granted; final value in all banks = 0x333.
- Core 0 writes 0x055 and core 1 reads, both at address 0x020, in the same cycle as a broadcast from core 2 -> core 0 `ready`=0; core 1 read completes with the old value.
- Banks hold 0x001, 0x002, 0x004, 0x008 at address 0x040 -> host read returns 0x00F after 1 cycle.
- Reset asserted during a read -> no `rvalid`; all outputs return to 0 and the FSM returns to INIT.
